// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sized accesses over a word-wide req/ack bus.
// Stalls the pipeline until the access completes, flags misalignment and bus timeouts.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic [3:0]  iMemControl,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic        oStall,
  output logic        oDone,
  output logic [31:0] oReadData,
  output logic        oMisaligned,
  output logic        oBusError,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWdata,
  output logic [3:0]  oBusByteEn,
  input  logic [31:0] iBusRdata,
  input  logic        iBusAck
);

  // state  | meaning
  // S_IDLE | waiting for a memory op
  // S_REQ  | bus request outstanding
  // S_DONE | one-cycle completion, results valid
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] C_LW = 4'b0000, C_LH = 4'b0001, C_LB = 4'b0010,
                         C_LHU = 4'b0011, C_LBU = 4'b0100, C_SW = 4'b0101,
                         C_SH = 4'b0110, C_SB = 4'b0111;

  state_t        r_state, w_next;
  logic          r_bus_req;
  logic [3:0]    r_code;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_mis;
  logic          r_err;

  logic          w_mem_op;
  logic          w_misaligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_timeout;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ext;

  assign w_mem_op  = iValid && !iMemControl[3];
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = iWriteData;
    case (iMemControl)
      C_LW, C_SW: w_misaligned = (iAddress[1:0] != 2'b00);
      C_LH, C_LHU, C_SH: begin
        w_misaligned = iAddress[0];
        w_be         = iAddress[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{iWriteData[15:0]}};
      end
      C_LB, C_LBU, C_SB: begin
        w_be    = 4'b0001 << iAddress[1:0];
        w_wdata = {4{iWriteData[7:0]}};
      end
      default: ;
    endcase
  end

  // Halves are always aligned here, so a byte-granular shift serves both sizes.
  assign w_shifted = iBusRdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = iBusRdata;
    case (r_code)
      C_LB:    w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      C_LBU:   w_ext = {24'd0, w_shifted[7:0]};
      C_LH:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      C_LHU:   w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = iBusRdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op) w_next = w_misaligned ? S_DONE : S_REQ;
      S_REQ:  if (iBusAck || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_bus_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_req <= (w_next == S_REQ);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_code  <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_mem_op) begin
          r_code  <= iMemControl;
          r_addr  <= iAddress;
          r_wdata <= w_wdata;
          r_be    <= w_be;
          r_we    <= (iMemControl == C_SW) || (iMemControl == C_SH) || (iMemControl == C_SB);
          r_mis   <= w_misaligned;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          if (w_misaligned) r_rdata <= 32'd0;
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (iBusAck) begin
            r_rdata <= r_we ? 32'd0 : w_ext;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oStall      = ((r_state == S_IDLE) && w_mem_op) || (r_state == S_REQ);
  assign oDone       = (r_state == S_DONE);
  assign oMisaligned = oDone && r_mis;
  assign oBusError   = oDone && r_err;
  assign oReadData   = r_rdata;
  assign oBusReq     = r_bus_req;
  assign oBusWe      = r_we;
  assign oBusAddr    = {r_addr[31:2], 2'b00};
  assign oBusWdata   = r_wdata;
  assign oBusByteEn  = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses with a scoreboard queue,
// plus hand sequences for reset, non-memory codes and reset during a request.
module tb_mem_access_unit;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic [3:0]  iMemControl;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        oStall, oDone, oMisaligned, oBusError, oBusReq, oBusWe;
  logic [31:0] oReadData, oBusAddr, oBusWdata;
  logic [3:0]  oBusByteEn;
  logic [31:0] iBusRdata;
  logic        iBusAck;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iMemControl(iMemControl),
    .iAddress(iAddress), .iWriteData(iWriteData), .oStall(oStall), .oDone(oDone),
    .oReadData(oReadData), .oMisaligned(oMisaligned), .oBusError(oBusError),
    .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWdata(oBusWdata),
    .oBusByteEn(oBusByteEn), .iBusRdata(iBusRdata), .iBusAck(iBusAck)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;      // -1: never ack
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic        chk_wdata;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_err;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int req = 0, stall = 0, lat = -1;
    sb.push_back(v);
    @(negedge iClk);
    iValid = 1'b1; iMemControl = v.code; iAddress = v.addr;
    iWriteData = v.wdata; iBusRdata = v.rdata; iBusAck = 1'b0;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (oDone) begin lat = cyc; break; end
      if (cyc == 0) check($sformatf("v%0d rdata_hold", idx), oReadData, prev_rdata);
      if (oStall) stall++;
      if (oBusReq) begin
        req++;
        if (req == 1) begin
          check($sformatf("v%0d bus_addr", idx), oBusAddr, v.exp_baddr);
          check($sformatf("v%0d byte_en", idx), {28'd0, oBusByteEn}, {28'd0, v.exp_be});
          check($sformatf("v%0d bus_we", idx), {31'd0, oBusWe}, {31'd0, v.exp_we});
          if (v.chk_wdata) check($sformatf("v%0d bus_wdata", idx), oBusWdata, v.exp_wdata);
        end
        iBusAck = (v.waits >= 0) && (req == v.waits + 1);
      end else begin
        iBusAck = 1'b0;
      end
      @(negedge iClk); #1;
    end
    iBusAck = 1'b0;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d done_wait: got no oDone expected oDone within 40 cycles", idx);
    end else if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d scoreboard: got oDone expected empty queue", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d read_data", idx), oReadData, e.exp_rdata);
      check($sformatf("v%0d misaligned", idx), {31'd0, oMisaligned}, {31'd0, e.exp_mis});
      check($sformatf("v%0d bus_error", idx), {31'd0, oBusError}, {31'd0, e.exp_err});
      check($sformatf("v%0d latency", idx), lat, e.exp_lat);
      check($sformatf("v%0d stall_cycles", idx), stall, e.exp_lat);
      check($sformatf("v%0d req_cycles", idx), req, e.exp_req);
      prev_rdata = e.exp_rdata;
    end
    @(posedge iClk); #1;
    iValid = 1'b0; iMemControl = 4'b1000;
    @(negedge iClk);
    check($sformatf("v%0d idle_after", idx), {29'd0, oDone, oStall, oBusReq}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sbv;
    //        code     addr          wdata         rdata        w   baddr         be       we  cw  exp_wdata     exp_rdata     mis  err  lat req
    vecs[0]  = '{4'b0010, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 32'h0000_1000, 4'b1000, 0, 0, 32'h0,        32'hFFFF_FF80, 0, 0, 2, 1};
    vecs[1]  = '{4'b0011, 32'h0000_2002, 32'h0,        32'h9ABC_0000, 3, 32'h0000_2000, 4'b1100, 0, 0, 32'h0,        32'h0000_9ABC, 0, 0, 5, 4};
    vecs[2]  = '{4'b0110, 32'h0000_3002, 32'h1111_BEEF, 32'hDEAD_BEEF, 0, 32'h0000_3000, 4'b1100, 1, 1, 32'hBEEF_BEEF, 32'h0,        0, 0, 2, 1};
    vecs[3]  = '{4'b0000, 32'h0000_4001, 32'h0,        32'h1234_5678, 0, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
    vecs[4]  = '{4'b0101, 32'h0000_6000, 32'h1234_5678, 32'h0,        -1, 32'h0000_6000, 4'b1111, 1, 1, 32'h1234_5678, 32'h0,        0, 1, 5, 4};
    vecs[5]  = '{4'b0001, 32'h0000_7000, 32'h0,        32'h0000_8001, 1, 32'h0000_7000, 4'b0011, 0, 0, 32'h0,        32'hFFFF_8001, 0, 0, 3, 2};
    vecs[6]  = '{4'b0100, 32'h0000_8001, 32'h0,        32'h1234_F0AA, 0, 32'h0000_8000, 4'b0010, 0, 0, 32'h0,        32'h0000_00F0, 0, 0, 2, 1};
    vecs[7]  = '{4'b0111, 32'h0000_9003, 32'h0000_0055, 32'h0,        0, 32'h0000_9000, 4'b1000, 1, 1, 32'h5555_5555, 32'h0,        0, 0, 2, 1};
    vecs[8]  = '{4'b0000, 32'h0000_A000, 32'h0,        32'hCAFE_F00D, 2, 32'h0000_A000, 4'b1111, 0, 0, 32'h0,        32'hCAFE_F00D, 0, 0, 4, 3};
    vecs[9]  = '{4'b0110, 32'h0000_B001, 32'h0000_1234, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
    vecs[10] = '{4'b0011, 32'h0000_C003, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
    vecs[11] = '{4'b0101, 32'h0000_D002, 32'h0000_0001, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
    vecs[12] = '{4'b0001, 32'h0000_E002, 32'h0,        32'h7FFF_0000, 0, 32'h0000_E000, 4'b1100, 0, 0, 32'h0,        32'h0000_7FFF, 0, 0, 2, 1};

    iRst = 1'b1; iValid = 1'b0; iMemControl = 4'b1000; iAddress = 32'h0;
    iWriteData = 32'h0; iBusRdata = 32'h0; iBusAck = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    check("reset outputs", {26'd0, oStall, oDone, oMisaligned, oBusError, oBusReq, oBusWe}, 32'd0);
    check("reset read_data", oReadData, 32'd0);
    check("reset bus_addr", oBusAddr, 32'd0);
    check("reset bus_wdata", oBusWdata, 32'd0);
    check("reset byte_en", {28'd0, oBusByteEn}, 32'd0);
    iRst = 1'b0;
    prev_rdata = 32'd0;

    // Non-memory codes, invalid memory ops and stray acks must leave the unit idle.
    @(negedge iClk);
    iValid = 1'b1; iMemControl = 4'b1000; iBusAck = 1'b1;
    #1; check("nonmem 1000 stall", {31'd0, oStall}, 32'd0);
    @(negedge iClk); iMemControl = 4'b1111;
    #1; check("nonmem 1111 stall", {31'd0, oStall}, 32'd0);
    @(negedge iClk); iValid = 1'b0; iMemControl = 4'b0000;
    #1; check("invalid lw stall", {31'd0, oStall}, 32'd0);
    @(negedge iClk);
    check("idle no activity", {30'd0, oDone, oBusReq}, 32'd0);
    iBusAck = 1'b0; iMemControl = 4'b1000;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset asserted while a request is outstanding aborts it silently.
    @(negedge iClk);
    iValid = 1'b1; iMemControl = 4'b0101; iAddress = 32'h0000_6100; iWriteData = 32'h0F0F_0F0F;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge iClk);
        if (oBusReq) begin seen = 1'b1; break; end
      end
      check("rst_req reached REQ", {31'd0, seen}, 32'd1);
    end
    iRst = 1'b1;
    @(posedge iClk); #1;
    check("rst_req bus_req dropped", {31'd0, oBusReq}, 32'd0);
    check("rst_req no done", {31'd0, oDone}, 32'd0);
    iRst = 1'b0; iValid = 1'b0; iMemControl = 4'b1000;
    begin
      int stray = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge iClk);
        if (oDone || oBusReq || oStall) stray++;
      end
      check("rst_req stays idle", stray, 0);
    end
    prev_rdata = 32'd0;

    sbv = '{4'b0111, 32'h0000_5001, 32'h0000_00AA, 32'h0, 0, 32'h0000_5000, 4'b0010, 1, 1,
            32'hAAAA_AAAA, 32'h0, 0, 0, 2, 1};
    run_vec(13, sbv);

    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
